// File: rtl/alu_ctrl_pkg.sv
// Shared funct codes, result-select encodings and sequencer state encoding for
// the EX-stage ALU op sequencer.
package alu_ctrl_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_SHT = 2'd1,
    RES_HI  = 2'd2,
    RES_LO  = 2'd3
  } res_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mc_cycle_counter.sv
// Iteration counter for multi-cycle units: load captures the limit and zeroes the
// count, clear aborts, tc_o flags the last enabled iteration (count == limit-1).
module mc_cycle_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      lim_q <= lim_q;
    end else if (load_i) begin
      cnt_q <= '0;
      lim_q <= limit_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
      lim_q <= lim_q;
    end else begin
      cnt_q <= cnt_q;
      lim_q <= lim_q;
    end
  end

  assign tc_o = en_i && (cnt_q == (lim_q - CNT_W'(1)));

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage funct decoder and multi-cycle op sequencer (DIVU, optional MULTU).
// Define ALU_MULTU_EN to make MULTU a sequenced multiplier op instead of illegal.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               flush_i,
  output logic [FUNCT_W-1:0] alu_op_o,
  output logic [FUNCT_W-1:0] sht_op_o,
  output logic               div_start_o,
  output logic               mul_start_o,
  output logic [1:0]         res_sel_o,
  output logic               hilo_we_o,
  output logic               stall_o,
  output logic               busy_o,
  output logic               illegal_o
);

  state_e             state_q;
  logic               hilo_we_q;
  logic               illegal_q;

  logic [FUNCT_W-1:0] dec_alu_op;
  logic [FUNCT_W-1:0] dec_sht_op;
  res_sel_e           dec_res_sel;
  logic               dec_div;
  logic               dec_mul;
  logic               dec_known;
  logic               start_ok;
  logic               tc;
  logic [CNT_W-1:0]   limit;

  always_comb begin
    dec_alu_op  = '0;
    dec_sht_op  = '0;
    dec_res_sel = RES_ALU;
    dec_div     = 1'b0;
    dec_mul     = 1'b0;
    dec_known   = 1'b1;
    if (op_valid_i) begin
      case (funct_i)
        FUNCT_W'(F_AND), FUNCT_W'(F_OR), FUNCT_W'(F_ADD),
        FUNCT_W'(F_SUB), FUNCT_W'(F_SLT): dec_alu_op = funct_i;
        FUNCT_W'(F_SLL): begin
          dec_sht_op  = funct_i;
          dec_res_sel = RES_SHT;
        end
        FUNCT_W'(F_MFHI): dec_res_sel = RES_HI;
        FUNCT_W'(F_MFLO): dec_res_sel = RES_LO;
        FUNCT_W'(F_DIVU): dec_div = 1'b1;
`ifdef ALU_MULTU_EN
        FUNCT_W'(F_MULTU): dec_mul = 1'b1;
`endif
        default: dec_known = 1'b0;
      endcase
    end else begin
      dec_known = 1'b1;
    end
  end

  // A new multi-cycle op may launch only from IDLE and never in a reset/flush cycle.
  assign start_ok = !rst && !flush_i && (state_q == ST_IDLE) && (dec_div || dec_mul);
  assign limit    = dec_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);

  mc_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .load_i  (start_ok),
    .limit_i (limit),
    .en_i    (state_q == ST_RUN),
    .tc_o    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hilo_we_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      state_q   <= ST_IDLE;
      hilo_we_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      hilo_we_q <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_RUN;
          end else begin
            state_q   <= ST_IDLE;
            illegal_q <= op_valid_i && !dec_known;
          end
        end
        ST_RUN: begin
          if (tc) begin
            state_q   <= ST_DONE;
            hilo_we_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_op_o    = dec_alu_op;
  assign sht_op_o    = dec_sht_op;
  assign res_sel_o   = dec_res_sel;
  assign div_start_o = start_ok && dec_div;
`ifdef ALU_MULTU_EN
  assign mul_start_o = start_ok && dec_mul;
`else
  assign mul_start_o = 1'b0;
`endif
  assign stall_o     = !rst && !flush_i && (start_ok || (state_q == ST_RUN));
  assign busy_o      = (state_q != ST_IDLE);
  assign hilo_we_o   = hilo_we_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (DIV_CYCLES=32, MUL_CYCLES=8).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid_i;
  logic [5:0] funct_i;
  logic       flush_i;
  logic [5:0] alu_op_o;
  logic [5:0] sht_op_o;
  logic       div_start_o;
  logic       mul_start_o;
  logic [1:0] res_sel_o;
  logic       hilo_we_o;
  logic       stall_o;
  logic       busy_o;
  logic       illegal_o;

  int checks   = 0;
  int failures = 0;
  int stall_n, hilo_n, hilo_at, start_n;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .FUNCT_W(6), .DIV_CYCLES(32), .MUL_CYCLES(8), .CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .funct_i(funct_i), .flush_i(flush_i),
    .alu_op_o(alu_op_o), .sht_op_o(sht_op_o), .div_start_o(div_start_o),
    .mul_start_o(mul_start_o), .res_sel_o(res_sel_o), .hilo_we_o(hilo_we_o),
    .stall_o(stall_o), .busy_o(busy_o), .illegal_o(illegal_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op_valid_i = 1'b1; funct_i = 6'd27; flush_i = 1'b0;

    // reset held for three cycles with DIVU presented
    repeat (3) begin
      tick();
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_div_start", {31'd0, div_start_o}, 32'd0);
    end
    rst = 1'b0; op_valid_i = 1'b0; funct_i = 6'd0; #1;
    chk("rel_stall", {31'd0, stall_o}, 32'd0);
    chk("rel_hilo", {31'd0, hilo_we_o}, 32'd0);
    chk("rel_busy", {31'd0, busy_o}, 32'd0);

    // single-cycle decode
    op_valid_i = 1'b1; funct_i = 6'd32; #1;
    chk("add_alu_op", {26'd0, alu_op_o}, 32'd32);
    chk("add_res_sel", {30'd0, res_sel_o}, 32'd0);
    chk("add_stall", {31'd0, stall_o}, 32'd0);
    funct_i = 6'd0; #1;
    chk("sll_sht_op", {26'd0, sht_op_o}, 32'd0);
    chk("sll_res_sel", {30'd0, res_sel_o}, 32'd1);
    chk("sll_alu_op", {26'd0, alu_op_o}, 32'd0);
    funct_i = 6'd18; #1;
    chk("mflo_res_sel", {30'd0, res_sel_o}, 32'd3);
    op_valid_i = 1'b0; funct_i = 6'd36; #1;
    chk("inv_alu_op", {26'd0, alu_op_o}, 32'd0);
    tick();
    chk("single_busy", {31'd0, busy_o}, 32'd0);

    // DIVU full sequence, op held while stalled
    op_valid_i = 1'b1; funct_i = 6'd27;
    stall_n = 0; hilo_n = 0; hilo_at = 0; start_n = 0;
    for (int c = 1; c <= 34; c++) begin
      #1;
      if (stall_o) stall_n++;
      if (div_start_o) start_n++;
      if (hilo_we_o) begin hilo_n++; hilo_at = c; end
      tick();
    end
    chk("divu_start_cnt", start_n, 32'd1);
    chk("divu_stall_cnt", stall_n, 32'd33);
    chk("divu_hilo_cnt", hilo_n, 32'd1);
    chk("divu_hilo_cycle", hilo_at, 32'd34);
    funct_i = 6'd16; #1;
    chk("mfhi_res_sel", {30'd0, res_sel_o}, 32'd2);
    chk("mfhi_stall", {31'd0, stall_o}, 32'd0);
    chk("mfhi_hilo", {31'd0, hilo_we_o}, 32'd0);
    chk("mfhi_busy", {31'd0, busy_o}, 32'd0);
    op_valid_i = 1'b0; tick();

    // DIVU flushed at RUN counter=10
    op_valid_i = 1'b1; funct_i = 6'd27; hilo_n = 0;
    for (int c = 1; c <= 11; c++) begin
      #1;
      if (hilo_we_o) hilo_n++;
      tick();
    end
    flush_i = 1'b1; #1;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_busy_before", {31'd0, busy_o}, 32'd1);
    chk("flush_div_start", {31'd0, div_start_o}, 32'd0);
    tick();
    flush_i = 1'b0; op_valid_i = 1'b0; #1;
    chk("flush_busy_after", {31'd0, busy_o}, 32'd0);
    chk("flush_stall_after", {31'd0, stall_o}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (hilo_we_o) hilo_n++;
      tick();
    end
    chk("flush_no_hilo", hilo_n, 32'd0);

    // illegal funct
    op_valid_i = 1'b1; funct_i = 6'd63; #1;
    chk("ill_same_cycle", {31'd0, illegal_o}, 32'd0);
    chk("ill_stall", {31'd0, stall_o}, 32'd0);
    chk("ill_res_sel", {30'd0, res_sel_o}, 32'd0);
    tick();
    op_valid_i = 1'b0; #1;
    chk("ill_pulse", {31'd0, illegal_o}, 32'd1);
    tick();
    chk("ill_pulse_end", {31'd0, illegal_o}, 32'd0);

`ifndef ALU_MULTU_EN
    op_valid_i = 1'b1; funct_i = 6'd25; #1;
    chk("multu_dis_start", {31'd0, mul_start_o}, 32'd0);
    chk("multu_dis_stall", {31'd0, stall_o}, 32'd0);
    tick();
    op_valid_i = 1'b0; #1;
    chk("multu_dis_illegal", {31'd0, illegal_o}, 32'd1);
    chk("multu_dis_busy", {31'd0, busy_o}, 32'd0);
`else
    op_valid_i = 1'b1; funct_i = 6'd25;
    stall_n = 0; hilo_n = 0; hilo_at = 0; start_n = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (stall_o) stall_n++;
      if (mul_start_o) start_n++;
      if (hilo_we_o) begin hilo_n++; hilo_at = c; end
      tick();
    end
    chk("multu_start_cnt", start_n, 32'd1);
    chk("multu_stall_cnt", stall_n, 32'd9);
    chk("multu_hilo_cnt", hilo_n, 32'd1);
    chk("multu_hilo_cycle", hilo_at, 32'd10);
    funct_i = 6'd27; #1;
    chk("b2b_div_start", {31'd0, div_start_o}, 32'd1);
    chk("b2b_stall", {31'd0, stall_o}, 32'd1);
    tick();
    flush_i = 1'b1; op_valid_i = 1'b0; tick();
    flush_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
